reg_write_scoreboard: RTL and testbench
=======================================

Name: reg_write_scoreboard

Overview:
- Writer-side tracker for register-file writes in the 5-stage pipeline.
- Records each destination register when a writing instruction issues into DX. Counts down to its writeback in MW, or to completion of a multi-cycle mult/div.
- Raises a stall toward PC/FD when the instruction in FD reads a pending register (RAW) or would overtake a longer pending write (WAW).
- Drives the FD/DX bubble-insertion logic alongside the existing combinational hazard check.

Parameters:
- CNT_W, 6, width of each per-register countdown.
- ALU_LAT, 3, cycles from issue to writeback for R-type ALU, addi, jal and setx.
- LW_LAT, 3, cycles from issue to writeback for lw.
- MD_LAT, 34, cycles from issue to writeback for mul/div. Must be less than 2^CNT_W.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  issue_insn advances into DX at this edge.
- issue_insn  in  32  instruction entering DX.
- flush  in  1  branch/jump squash; kills this cycle's issue and younger entries.
- fd_insn  in  32  instruction currently in FD (query).
- stall  out  1  hold PC and FD, insert nop into DX (combinational).
- stall_raw  out  1  cause: RAW hit.
- stall_waw  out  1  cause: WAW hit.
- busy_vec  out  32  bit r = register r has a pending write.

Behaviour:
- Decode, fields as in ISA: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- Writers:
  - R-type 00000 writes rd. Latency MD_LAT if ALU op 00110 (mul) or 00111 (div), else ALU_LAT.
  - addi 00101 writes rd, ALU_LAT.
  - lw 01000 writes rd, LW_LAT.
  - jal 00011 writes r31, ALU_LAT.
  - setx 10101 writes r30, ALU_LAT.
  - A write to r0 is never tracked.
- Sources of fd_insn:
  - R-type: rs, rt.
  - addi, lw: rs.
  - sw 00111, bne 00010, blt 00110: rd, rs.
  - jr 00100: rd.
  - bex 10110: r30.
  - All other opcodes: none. r0 never matches.
- State per register r1..r31: cnt[CNT_W-1:0] and a young bit.
- Each edge, for every r: if cnt != 0 then cnt decrements; young clears.
- Issue (issue_valid=1, flush=0, writer, dest d != 0): cnt[d] is loaded with the latency and young[d] is set. The load overrides the decrement.
- flush=1: issue is ignored, and every entry with young=1 is cleared to cnt=0.
- busy(r) = cnt[r] != 0, OR (issue_valid & ~flush & issue dest == r, r != 0).
- stall_raw = any fd source s with busy(s).
- stall_waw: fd_insn is a writer to d, and its latency is < cnt[d] - 1.
- stall = stall_raw | stall_waw.
- Same-cycle issue and expiry of the same register: the load wins.
- reset_n low: all cnt=0, all young=0. stall, stall_raw, stall_waw and busy_vec are forced 0 while reset_n is low.
- Reset mid-operation discards all pending entries immediately; no edge is required.
- busy_vec[0] is always 0.

Optional Feature:
- Macro SCOREBOARD_WB_BYPASS_EN.
- Defined: the register file writes in the first half-cycle, so an entry with cnt == 1 (writeback this edge) is not busy for RAW. Dependent instructions issue one cycle earlier.
- Undefined: cnt == 1 counts as busy. The RAW stall lasts until the entry reaches 0.

Test Plan:
- Reset: pulse reset_n low mid-run with r5 pending → busy_vec=0 and stall=0 asynchronously; both stay 0 after release.
- RAW: issue addi r5,r0,7, then hold fd=add r6,r5,r1 → stall=1 for 3 cycles (2 with SCOREBOARD_WB_BYPASS_EN), then 0; stall_raw matches stall.
- Mul latency: issue mul r3,r1,r2, fd=sw r3,0(r4) → stall for 34 cycles (33 with bypass); busy_vec[3] falls exactly at count 0.
- WAW: mul r7 in flight with cnt=20, fd=addi r7,r0,1 → stall_waw=1 until cnt ≤ 4, stall_raw=0.
- Flush: issue lw r9 with flush=1 → busy_vec[9]=0. Issue lw r9, then flush next cycle → young entry cleared, busy_vec[9]=0.
- r0 and non-readers: fd=add r1,r0,r0 with all registers pending → stall=0; issue addi r0,r1,5 → busy_vec stays 0.

Source files
------------

// File: rtl/reg_write_scoreboard.sv
// Writer-side register scoreboard: per-register countdowns to writeback that raise RAW/WAW stalls for FD.
// Optional build macro SCOREBOARD_WB_BYPASS_EN: register file writes in the first half-cycle (cnt==1 is not a RAW hazard).
module reg_write_scoreboard #(
  parameter int CNT_W   = 6,
  parameter int ALU_LAT = 3,
  parameter int LW_LAT  = 3,
  parameter int MD_LAT  = 34
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [31:0] issue_insn,
  input  logic        flush,
  input  logic [31:0] fd_insn,
  output logic        stall,
  output logic        stall_raw,
  output logic        stall_waw,
  output logic [31:0] busy_vec
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LW_CNT  = CNT_W'(LW_LAT);
  localparam logic [CNT_W-1:0] MD_CNT  = CNT_W'(MD_LAT);

  typedef struct packed {
    logic             wr;
    logic [4:0]       dest;
    logic [CNT_W-1:0] lat;
  } wr_info_t;

  // Writes to r0 are reported as non-writers so they are never tracked or compared.
  function automatic wr_info_t decode_write(input logic [4:0] op, input logic [4:0] rd,
                                            input logic [4:0] alu_op);
    wr_info_t info;
    info = '0;
    case (op)
      OP_RTYPE: begin
        info.wr   = 1'b1;
        info.dest = rd;
        info.lat  = (alu_op == ALU_MUL || alu_op == ALU_DIV) ? MD_CNT : ALU_CNT;
      end
      OP_ADDI: begin
        info.wr   = 1'b1;
        info.dest = rd;
        info.lat  = ALU_CNT;
      end
      OP_LW: begin
        info.wr   = 1'b1;
        info.dest = rd;
        info.lat  = LW_CNT;
      end
      OP_JAL: begin
        info.wr   = 1'b1;
        info.dest = 5'd31;
        info.lat  = ALU_CNT;
      end
      OP_SETX: begin
        info.wr   = 1'b1;
        info.dest = 5'd30;
        info.lat  = ALU_CNT;
      end
      default: ;
    endcase
    if (info.dest == 5'd0) info.wr = 1'b0;
    return info;
  endfunction

  function automatic logic [31:0] decode_sources(input logic [4:0] op, input logic [4:0] rd,
                                                 input logic [4:0] rs, input logic [4:0] rt);
    logic [31:0] mask;
    mask = '0;
    case (op)
      OP_RTYPE: begin
        mask[rs] = 1'b1;
        mask[rt] = 1'b1;
      end
      OP_ADDI, OP_LW: mask[rs] = 1'b1;
      OP_SW, OP_BNE, OP_BLT: begin
        mask[rd] = 1'b1;
        mask[rs] = 1'b1;
      end
      OP_JR:   mask[rd] = 1'b1;
      OP_BEX:  mask[30] = 1'b1;
      default: ;
    endcase
    mask[0] = 1'b0;
    return mask;
  endfunction

  wr_info_t    issue_info;
  wr_info_t    fd_info;
  logic [31:0] fd_src;
  logic        issue_live;
  logic [31:0] busy_raw;
  logic [31:0] raw_busy;
  logic [31:0] waw_hit;
  logic        unused_insn_bits;

  assign issue_info = decode_write(issue_insn[31:27], issue_insn[26:22], issue_insn[6:2]);
  assign fd_info    = decode_write(fd_insn[31:27], fd_insn[26:22], fd_insn[6:2]);
  assign fd_src     = decode_sources(fd_insn[31:27], fd_insn[26:22], fd_insn[21:17], fd_insn[16:12]);
  assign issue_live = issue_valid & ~flush & issue_info.wr;

  assign unused_insn_bits = ^{issue_insn[21:7], issue_insn[1:0], fd_insn[11:7], fd_insn[1:0]};

  assign busy_raw[0] = 1'b0;
  assign raw_busy[0] = 1'b0;
  assign waw_hit[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_entry
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             young_reg;
      logic             young_next;
      logic             hit;

      assign hit = issue_live && (issue_info.dest == 5'(gi));

      // A flush kills only entries loaded on the previous edge; a fresh load beats the decrement.
      always_comb begin
        cnt_next   = cnt_reg;
        young_next = hit;
        if (flush && young_reg) begin
          cnt_next = '0;
        end else if (hit) begin
          cnt_next = issue_info.lat;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg   <= '0;
          young_reg <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          young_reg <= young_next;
        end
      end

      assign busy_raw[gi] = (cnt_reg != '0) | hit;
`ifdef SCOREBOARD_WB_BYPASS_EN
      assign raw_busy[gi] = (cnt_reg > CNT_W'(1)) | hit;
`else
      assign raw_busy[gi] = busy_raw[gi];
`endif
      // lat < cnt - 1, rewritten as lat + 1 < cnt so cnt == 0 cannot underflow.
      assign waw_hit[gi] = fd_info.wr && (fd_info.dest == 5'(gi)) &&
                           (({1'b0, fd_info.lat} + (CNT_W + 1)'(1)) < {1'b0, cnt_reg});
    end
  endgenerate

  always_comb begin
    stall_raw = 1'b0;
    stall_waw = 1'b0;
    busy_vec  = '0;
    if (reset_n) begin
      stall_raw = |(fd_src & raw_busy);
      stall_waw = |waw_hit;
      busy_vec  = busy_raw;
    end
    stall = stall_raw | stall_waw;
  end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Randomized + directed bench for reg_write_scoreboard; model tracks absolute writeback times per register.
module tb_reg_write_scoreboard;

  localparam int ALU_LAT = 3;
  localparam int LW_LAT  = 3;
  localparam int MD_LAT  = 34;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_insn = '0;
  logic        flush = 1'b0;
  logic [31:0] fd_insn = '0;
  logic        stall;
  logic        stall_raw;
  logic        stall_waw;
  logic [31:0] busy_vec;

  reg_write_scoreboard dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .issue_valid(issue_valid),
    .issue_insn (issue_insn),
    .flush      (flush),
    .fd_insn    (fd_insn),
    .stall      (stall),
    .stall_raw  (stall_raw),
    .stall_waw  (stall_waw),
    .busy_vec   (busy_vec)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        stall;
    logic        raw;
    logic        waw;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   t = 0;
  int   wb[32];
  int   load_edge[32];

  function automatic logic [31:0] r_insn(int rd, int rs, int rt, int alu);
    return {OP_R, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
  endfunction

  function automatic logic [31:0] i_insn(logic [4:0] op, int rd, int rs, int imm);
    return {op, 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  function automatic logic [31:0] j_insn(logic [4:0] op, int target);
    return {op, 27'(target)};
  endfunction

  function automatic bit writes(input logic [31:0] i, output int d, output int lat);
    d = 0;
    lat = 0;
    case (i[31:27])
      OP_R: begin
        d = int'(i[26:22]);
        lat = (i[6:2] == 5'b00110 || i[6:2] == 5'b00111) ? MD_LAT : ALU_LAT;
      end
      OP_ADDI: begin d = int'(i[26:22]); lat = ALU_LAT; end
      OP_LW:   begin d = int'(i[26:22]); lat = LW_LAT; end
      OP_JAL:  begin d = 31; lat = ALU_LAT; end
      OP_SETX: begin d = 30; lat = ALU_LAT; end
      default: return 1'b0;
    endcase
    return d != 0;
  endfunction

  function automatic void sources(input logic [31:0] i, output int s0, output int s1);
    s0 = 0;
    s1 = 0;
    case (i[31:27])
      OP_R:                  begin s0 = int'(i[21:17]); s1 = int'(i[16:12]); end
      OP_ADDI, OP_LW:        s0 = int'(i[21:17]);
      OP_SW, OP_BNE, OP_BLT: begin s0 = int'(i[26:22]); s1 = int'(i[21:17]); end
      OP_JR:                 s0 = int'(i[26:22]);
      OP_BEX:                s0 = 30;
      default: ;
    endcase
  endfunction

  function automatic int cnt_of(int r);
    return (wb[r] > t) ? wb[r] - t : 0;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) begin
      wb[r] = 0;
      load_edge[r] = -1;
    end
  endfunction

  // Applies the inputs that were held during the cycle ending at this edge.
  function automatic void model_edge();
    int d, lat;
    t++;
    if (!reset_n) begin
      model_clear();
    end else if (flush) begin
      for (int r = 1; r < 32; r++)
        if (load_edge[r] == t - 1) begin
          wb[r] = 0;
          load_edge[r] = -1;
        end
    end else if (issue_valid && writes(issue_insn, d, lat)) begin
      wb[d] = t + lat;
      load_edge[d] = t;
    end
  endfunction

  function automatic exp_t model_expect();
    exp_t        e;
    int          d, lat, s0, s1, id, ilat;
    bit          issuing;
    logic [31:0] rawb;
    e.cyc = t; e.stall = 1'b0; e.raw = 1'b0; e.waw = 1'b0; e.busy = '0;
    rawb = '0;
    if (!reset_n) return e;
    issuing = issue_valid && !flush && writes(issue_insn, id, ilat);
    for (int r = 1; r < 32; r++) begin
      int c;
      bit iss;
      c = cnt_of(r);
      iss = issuing && (id == r);
      e.busy[r] = (c > 0) || iss;
`ifdef SCOREBOARD_WB_BYPASS_EN
      rawb[r] = (c > 1) || iss;
`else
      rawb[r] = e.busy[r];
`endif
    end
    sources(fd_insn, s0, s1);
    e.raw = (s0 != 0 && rawb[s0]) || (s1 != 0 && rawb[s1]);
    if (writes(fd_insn, d, lat)) e.waw = (lat < cnt_of(d) - 1);
    e.stall = e.raw || e.waw;
    return e;
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response to score.
  exp_t mon_e;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("stall", mon_e.cyc, 32'(stall), 32'(mon_e.stall));
      check("stall_raw", mon_e.cyc, 32'(stall_raw), 32'(mon_e.raw));
      check("stall_waw", mon_e.cyc, 32'(stall_waw), 32'(mon_e.waw));
      check("busy_vec", mon_e.cyc, busy_vec, mon_e.busy);
      $display("cyc %0d rst_n=%b iv=%b fl=%b stall=%b raw=%b waw=%b busy=%h",
               mon_e.cyc, reset_n, issue_valid, flush, stall, stall_raw, stall_waw, busy_vec);
    end
  end

  task automatic step(input logic iv, input logic [31:0] ins, input logic fl,
                      input logic [31:0] fd, input logic rst);
    issue_valid = iv;
    issue_insn  = ins;
    flush       = fl;
    fd_insn     = fd;
    reset_n     = rst;
    if (!rst) model_clear();
    exp_q.push_back(model_expect());
    @(posedge clock);
    #1;
    model_edge();
  endtask

  function automatic int rand_reg();
    int k;
    k = $urandom_range(0, 7);
    return (k == 6) ? 30 : (k == 7) ? 31 : k;
  endfunction

  function automatic logic [31:0] rand_insn();
    int pick;
    pick = $urandom_range(0, 12);
    case (pick)
      0:  return r_insn(rand_reg(), rand_reg(), rand_reg(), $urandom_range(0, 5));
      1:  return r_insn(rand_reg(), rand_reg(), rand_reg(), 6);
      2:  return r_insn(rand_reg(), rand_reg(), rand_reg(), 7);
      3:  return i_insn(OP_ADDI, rand_reg(), rand_reg(), $urandom_range(0, 100));
      4:  return i_insn(OP_LW, rand_reg(), rand_reg(), $urandom_range(0, 100));
      5:  return j_insn(OP_JAL, $urandom);
      6:  return j_insn(OP_SETX, $urandom);
      7:  return i_insn(OP_SW, rand_reg(), rand_reg(), 4);
      8:  return i_insn(OP_BNE, rand_reg(), rand_reg(), 8);
      9:  return i_insn(OP_BLT, rand_reg(), rand_reg(), 8);
      10: return i_insn(OP_JR, rand_reg(), 0, 0);
      11: return j_insn(OP_BEX, $urandom);
      default: return j_insn(OP_J, $urandom);
    endcase
  endfunction

  initial begin
    model_clear();
    @(posedge clock);
    #1;
    // Reset state
    repeat (3) step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    // RAW on addi r5 with a dependent add in FD
    step(1'b1, i_insn(OP_ADDI, 5, 0, 7), 1'b0, '0, 1'b1);
    repeat (6) step(1'b0, '0, 1'b0, r_insn(6, 5, 1, 0), 1'b1);
    // mul r3 followed by sw reading r3
    step(1'b1, r_insn(3, 1, 2, 6), 1'b0, '0, 1'b1);
    repeat (37) step(1'b0, '0, 1'b0, i_insn(OP_SW, 3, 4, 0), 1'b1);
    // WAW: short addi r7 behind a long mul r7
    step(1'b1, r_insn(7, 1, 2, 6), 1'b0, '0, 1'b1);
    repeat (14) step(1'b0, '0, 1'b0, '0, 1'b1);
    repeat (20) step(1'b0, '0, 1'b0, i_insn(OP_ADDI, 7, 0, 1), 1'b1);
    // Flush on the issue cycle, then flush of a young entry
    step(1'b1, i_insn(OP_LW, 9, 1, 0), 1'b1, '0, 1'b1);
    step(1'b1, i_insn(OP_LW, 9, 1, 0), 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1, '0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, '0, 1'b1);
    // r0 never matches; every register pending
    for (int r = 2; r < 32; r++) step(1'b1, r_insn(r, 1, 2, 6), 1'b0, r_insn(1, 0, 0, 0), 1'b1);
    step(1'b1, i_insn(OP_ADDI, 1, 0, 1), 1'b0, r_insn(1, 0, 0, 0), 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, r_insn(1, 0, 0, 0), 1'b1);
    repeat (40) step(1'b0, '0, 1'b0, '0, 1'b1);
    repeat (3) step(1'b1, i_insn(OP_ADDI, 0, 1, 5), 1'b0, '0, 1'b1);
    // Reset mid-run with r5 pending
    step(1'b1, r_insn(5, 1, 2, 7), 1'b0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, r_insn(6, 5, 1, 0), 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, r_insn(6, 5, 1, 0), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, r_insn(6, 5, 1, 0), 1'b1);
    // Random traffic
    repeat (400) begin
      step(1'($urandom_range(0, 1)), rand_insn(), 1'($urandom_range(0, 9) == 0),
           rand_insn(), 1'($urandom_range(0, 99) != 0));
    end
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
